// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding
// and the default timing constants for a 100 MHz system clock.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_REL_DB   = 3'd4
  } key_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;   // 20 ms
  localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms
  localparam int DEF_CNT_W           = 26;

  // The debounced level is high in every state that follows an accepted press.
  function automatic logic is_pressed_state(input key_state_t st);
    logic p_s;
    case (st)
      ST_HOLD, ST_REPEAT, ST_REL_DB: p_s = 1'b1;
      default:                      p_s = 1'b0;
    endcase
    return p_s;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops clear on the synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_r;
  logic ff2_r;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ff1_r <= 1'b0;
      ff2_r <= 1'b0;
    end else begin
      ff1_r <= d;
      ff2_r <= ff1_r;
    end
  end

  assign q = ff2_r;

endmodule

// File: rtl/key_repeat_detector.sv
// Debounced push-button press detector with auto-repeat.
// One valid pulse per accepted press, then repeat pulses while held.
// A single counter times debounce, repeat delay and repeat period; it is
// cleared whenever the FSM changes state or a repeat pulse is issued.
module key_repeat_detector
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_ENA      = 1'b1,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic valid,
  output logic pressed,
  output logic repeating
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sig_s;
  key_state_t       state_r;
  key_state_t       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             pulse_s;
  logic             valid_r;
  logic             pressed_r;
  logic             repeating_r;
  logic             repeating_next_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig),
    .q   (sig_s)
  );

  // Next-state and pulse decode; a low input always wins over a terminal count.
  always_comb begin
    next_state_s = state_r;
    pulse_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sig_s) next_state_s = ST_PRESS_DB;
        else       next_state_s = ST_IDLE;
      end
      ST_PRESS_DB: begin
        if (!sig_s) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == DB_LAST) begin
          next_state_s = ST_HOLD;
          pulse_s      = 1'b1;
        end else begin
          next_state_s = ST_PRESS_DB;
        end
      end
      ST_HOLD: begin
        if (!sig_s) begin
          next_state_s = ST_REL_DB;
        end else if (REPEAT_ENA && (cnt_r == DLY_LAST)) begin
          next_state_s = ST_REPEAT;
          pulse_s      = 1'b1;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_REPEAT: begin
        if (!sig_s) begin
          next_state_s = ST_REL_DB;
        end else if (cnt_r == PER_LAST) begin
          next_state_s = ST_REPEAT;
          pulse_s      = 1'b1;
        end else begin
          next_state_s = ST_REPEAT;
        end
      end
      ST_REL_DB: begin
        if (sig_s) begin
          next_state_s = ST_HOLD;
        end else if (cnt_r == DB_LAST) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_REL_DB;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Shared timer: restart on any state change or repeat pulse, idle parks at zero.
  always_comb begin
    cnt_next_s = cnt_r;
    if ((next_state_s != state_r) || pulse_s || (state_r == ST_IDLE)) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Repeat indication survives release debounce but drops on a bounce back to HOLD.
  always_comb begin
    repeating_next_s = 1'b0;
    case (next_state_s)
      ST_REPEAT: repeating_next_s = 1'b1;
      ST_REL_DB: repeating_next_s = repeating_r;
      default:   repeating_next_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      valid_r     <= 1'b0;
      pressed_r   <= 1'b0;
      repeating_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= cnt_next_s;
      valid_r     <= pulse_s;
      pressed_r   <= is_pressed_state(next_state_s);
      repeating_r <= repeating_next_s;
    end
  end

  assign valid     = valid_r;
  assign pressed   = pressed_r;
  assign repeating = repeating_r;

endmodule

// File: tb/tb_key_repeat_detector.sv
// Scoreboard bench for key_repeat_detector. Two instances share the input:
// instance 0 with auto-repeat, instance 1 without. A run-length reference
// model predicts pulse edges and output levels as stimulus is issued; a
// monitor compares them against the DUT outputs after every clock edge.
module tb_key_repeat_detector;

  localparam int D      = 4;
  localparam int DELAY  = 20;
  localparam int PERIOD = 8;
  localparam int CW     = 5;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic valid0, pressed0, repeating0;
  logic valid1, pressed1, repeating1;

  always #5 clk = ~clk;

  key_repeat_detector #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD),
    .REPEAT_ENA      (1'b1),
    .CNT_W           (CW)
  ) dut0 (
    .clk (clk), .rst (rst), .sig (sig),
    .valid (valid0), .pressed (pressed0), .repeating (repeating0)
  );

  key_repeat_detector #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD),
    .REPEAT_ENA      (1'b0),
    .CNT_W           (CW)
  ) dut1 (
    .clk (clk), .rst (rst), .sig (sig),
    .valid (valid1), .pressed (pressed1), .repeating (repeating1)
  );

  // Scoreboard queues: expected pulse edge indices and per-edge {pressed, repeating}.
  int         exp_pulse_q0[$];
  int         exp_pulse_q1[$];
  logic [1:0] exp_lvl_q0[$];
  logic [1:0] exp_lvl_q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int stim_edge = 0;
  int mon_edge = 0;

  // Reference model state (per instance): input delay line, run length of the
  // level seen by the detector, debounced level, repeat flag, hold start edge.
  bit m_ff1[2], m_ff2[2], m_run_val[2], m_pressed[2], m_rep[2];
  int m_run_len[2], m_hold[2];

  task automatic model_step(input int i, input bit ena, input int k, input bit s, input bit r);
    bit seen;
    bit pulse;
    pulse = 1'b0;
    if (!r) begin
      m_ff1[i] = 1'b0; m_ff2[i] = 1'b0;
      m_run_val[i] = 1'b0; m_run_len[i] = 0;
      m_pressed[i] = 1'b0; m_rep[i] = 1'b0; m_hold[i] = 0;
    end else begin
      seen     = m_ff2[i];
      m_ff2[i] = m_ff1[i];
      m_ff1[i] = s;
      if (seen == m_run_val[i]) m_run_len[i]++;
      else begin m_run_val[i] = seen; m_run_len[i] = 1; end
      if (!m_pressed[i]) begin
        // A press is accepted once the high level has been seen D+1 edges in a row.
        if (seen && m_run_len[i] == D + 1) begin
          pulse = 1'b1; m_pressed[i] = 1'b1; m_hold[i] = k;
        end
      end else if (!seen) begin
        // Release accepted after D+1 consecutive low edges.
        if (m_run_len[i] == D + 1) begin
          m_pressed[i] = 1'b0; m_rep[i] = 1'b0;
        end
      end else begin
        if (m_run_len[i] == 1) begin
          // Came back high during release debounce: repeat timing restarts.
          m_hold[i] = k; m_rep[i] = 1'b0;
        end else if (ena && (k - m_hold[i]) >= DELAY &&
                     ((k - m_hold[i] - DELAY) % PERIOD) == 0) begin
          pulse = 1'b1; m_rep[i] = 1'b1;
        end
      end
    end
    if (i == 0) begin
      if (pulse) exp_pulse_q0.push_back(k);
      exp_lvl_q0.push_back({m_pressed[i], m_rep[i]});
    end else begin
      if (pulse) exp_pulse_q1.push_back(k);
      exp_lvl_q1.push_back({m_pressed[i], m_rep[i]});
    end
  endtask

  // Drive one cycle of stimulus for the next rising edge and record expectations.
  task automatic cycle(input bit s, input bit r);
    sig = s;
    rst = r;
    model_step(0, 1'b1, stim_edge, s, r);
    model_step(1, 1'b0, stim_edge, s, r);
    stim_edge++;
    @(negedge clk);
  endtask

  task automatic run(input bit s, input int n);
    for (int j = 0; j < n; j++) cycle(s, 1'b1);
  endtask

  // Compare one instance's outputs for edge e against the queued expectations.
  task automatic check_inst(input int i, input int e, input logic v, input logic p, input logic rp);
    logic [1:0] lv;
    int         front;
    bit         have_lvl;
    bit         have_p;
    have_lvl = (i == 0) ? (exp_lvl_q0.size() > 0) : (exp_lvl_q1.size() > 0);
    if (have_lvl) begin
      lv = (i == 0) ? exp_lvl_q0.pop_front() : exp_lvl_q1.pop_front();
      n_cmp++;
      if (p !== lv[1]) begin
        n_bad++;
        $display("FAIL pressed inst%0d edge %0d: got %b expected %b", i, e, p, lv[1]);
      end
      n_cmp++;
      if (rp !== lv[0]) begin
        n_bad++;
        $display("FAIL repeating inst%0d edge %0d: got %b expected %b", i, e, rp, lv[0]);
      end
    end
    have_p = (i == 0) ? (exp_pulse_q0.size() > 0) : (exp_pulse_q1.size() > 0);
    front  = !have_p ? -1 : ((i == 0) ? exp_pulse_q0[0] : exp_pulse_q1[0]);
    while (have_p && front < e) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_pulse inst%0d edge %0d: got no pulse expected pulse at edge %0d", i, e, front);
      if (i == 0) void'(exp_pulse_q0.pop_front()); else void'(exp_pulse_q1.pop_front());
      have_p = (i == 0) ? (exp_pulse_q0.size() > 0) : (exp_pulse_q1.size() > 0);
      front  = !have_p ? -1 : ((i == 0) ? exp_pulse_q0[0] : exp_pulse_q1[0]);
    end
    if (v !== 1'b0) begin
      n_cmp++;
      if (v === 1'b1 && have_p && front == e) begin
        if (i == 0) void'(exp_pulse_q0.pop_front()); else void'(exp_pulse_q1.pop_front());
      end else begin
        n_bad++;
        $display("FAIL unexpected_pulse inst%0d edge %0d: got valid=%b expected 0 (next expected edge %0d)",
                 i, e, v, front);
      end
    end
  endtask

  // Monitor: sample just after each rising edge and score both instances.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_inst(0, mon_edge, valid0, pressed0, repeating0);
      check_inst(1, mon_edge, valid1, pressed1, repeating1);
      mon_edge++;
    end
  end

  // Stimulus: directed scenarios followed by randomized press/bounce runs.
  initial begin
    bit lvl;
    int len;
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0);
    run(1'b0, 5);
    // clean press held 10 cycles, then release
    run(1'b1, 10); run(1'b0, 15);
    // bounce: short highs, then a stable high
    run(1'b1, 1); run(1'b0, 2); run(1'b1, 2); run(1'b0, 2); run(1'b1, 3); run(1'b0, 2);
    run(1'b1, 10); run(1'b0, 12);
    // long hold with auto-repeat
    run(1'b1, 60); run(1'b0, 12);
    // 2-cycle low glitch while repeating
    run(1'b1, 35); run(1'b0, 2); run(1'b1, 40); run(1'b0, 12);
    // reset mid-repeat with the button held
    run(1'b1, 34); cycle(1'b1, 1'b0); run(1'b1, 20); run(1'b0, 12);
    // 100-cycle hold (single pulse on the non-repeating instance)
    run(1'b1, 100); run(1'b0, 12);
    // randomized levels and durations
    for (int j = 0; j < 30; j++) begin
      lvl = 1'($urandom_range(0, 1));
      len = lvl ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 10));
      run(lvl, len);
    end
    run(1'b0, 15);
    // anything still queued was never produced
    while (exp_pulse_q0.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_pulse inst0 end: got no pulse expected pulse at edge %0d", exp_pulse_q0.pop_front());
    end
    while (exp_pulse_q1.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_pulse inst1 end: got no pulse expected pulse at edge %0d", exp_pulse_q1.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
